// File: rtl/scmi_arb_pkg.sv
// rtl/scmi_arb_pkg.sv - shared types and helpers for the SCMI doorbell arbiter
package scmi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NOTIFY  = 2'd1,
    SERVICE = 2'd2
  } arb_state_e;

  // Channel id width; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scmi_rr_picker.sv
// rtl/scmi_rr_picker.sv - combinational round-robin pick of the first pending channel at or after the pointer
module scmi_rr_picker
  import scmi_arb_pkg::*;
#(
  parameter int N_CHAN = 4,
  localparam int CHAN_W = chan_w(N_CHAN)
) (
  input  logic [N_CHAN-1:0] pending,
  input  logic [CHAN_W-1:0] ptr,
  output logic              found,
  output logic [CHAN_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N_CHAN;
      if (pending[c]) begin
        found = 1'b1;
        idx   = CHAN_W'(c);
      end
    end
  end

endmodule

// File: rtl/scmi_doorbell_arbiter.sv
// rtl/scmi_doorbell_arbiter.sv - round-robin sharing of one SCMI platform agent between mailbox channels
module scmi_doorbell_arbiter
  import scmi_arb_pkg::*;
#(
  parameter int N_CHAN         = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CHAN_W        = chan_w(N_CHAN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_CHAN-1:0] doorbell_i,
  output logic              irq_o,
  output logic [CHAN_W-1:0] chan_id_o,
  input  logic              claim_i,
  input  logic              complete_i,
  output logic [N_CHAN-1:0] completion_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [N_CHAN-1:0] overrun_o,
  input  logic [N_CHAN-1:0] overrun_clr_i
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = '1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(N_CHAN - 1);

  arb_state_e          state_q, state_d;
  logic [N_CHAN-1:0]   pending_q;
  logic [N_CHAN-1:0]   clr_mask;
  logic [CHAN_W-1:0]   ptr_q, ptr_d;
  logic [CHAN_W-1:0]   chan_d;
  logic [CHAN_W-1:0]   next_ptr;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [N_CHAN-1:0]   comp_d;
  logic                tmo_d;
  logic                pick_found;
  logic [CHAN_W-1:0]   pick_idx;

  scmi_rr_picker #(.N_CHAN(N_CHAN)) u_picker (
    .pending (pending_q),
    .ptr     (ptr_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // The channel just served drops to lowest priority next round.
  assign next_ptr = (chan_id_o == LAST_CHAN) ? '0 : chan_id_o + 1'b1;

  // Next state, pointer, watchdog and registered-output values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    chan_d   = chan_id_o;
    wd_d     = wd_q;
    clr_mask = '0;
    comp_d   = '0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          chan_d  = pick_idx;
          state_d = NOTIFY;
        end
      end
      NOTIFY: begin
        if (claim_i) begin
          clr_mask[chan_id_o] = 1'b1;
          wd_d    = '0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        if (complete_i) begin
          comp_d[chan_id_o] = 1'b1;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LIMIT) begin
          tmo_d   = 1'b1;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request bookkeeping and output registers; new doorbells beat claims and clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      wd_q         <= '0;
      irq_o        <= 1'b0;
      chan_id_o    <= '0;
      busy_o       <= 1'b0;
      completion_o <= '0;
      timeout_o    <= 1'b0;
      overrun_o    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= (pending_q & ~clr_mask) | doorbell_i;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      irq_o        <= (state_d == NOTIFY);
      chan_id_o    <= chan_d;
      busy_o       <= (state_d == SERVICE);
      completion_o <= comp_d;
      timeout_o    <= tmo_d;
      overrun_o    <= (overrun_o & ~overrun_clr_i) | (doorbell_i & pending_q);
    end
  end

endmodule

// File: tb/tb_scmi_doorbell_arbiter.sv
// tb/tb_scmi_doorbell_arbiter.sv - directed scoreboard bench for scmi_doorbell_arbiter
module tb_scmi_doorbell_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] doorbell_i = '0;
  logic       claim_i = 1'b0;
  logic       complete_i = 1'b0;
  logic [3:0] overrun_clr_i = '0;
  logic       irq_o;
  logic [1:0] chan_id_o;
  logic [3:0] completion_o;
  logic       busy_o;
  logic       timeout_o;
  logic [3:0] overrun_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  scmi_doorbell_arbiter #(.N_CHAN(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .doorbell_i    (doorbell_i),
    .irq_o         (irq_o),
    .chan_id_o     (chan_id_o),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .completion_o  (completion_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ring(input logic [3:0] mask);
    doorbell_i = mask;
    tick();
    doorbell_i = '0;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 40 && irq_o !== 1'b1; i++) tick();
    chk({tag, "_irq_wait"}, irq_o, 1);
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return 15;
    return exp_q.pop_front();
  endfunction

  task automatic serve(input string tag);
    int e;
    wait_irq(tag);
    e = pop_exp();
    chk({tag, "_chan"}, chan_id_o, e);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_irq_low"}, irq_o, 0);
    complete_i = 1'b1;
    tick();
    complete_i = 1'b0;
    chk({tag, "_completion"}, completion_o, (e < 4) ? (32'd1 << e) : 32'hffff);
    chk({tag, "_busy_low"}, busy_o, 0);
  endtask

  initial begin
    int e;
    // Reset state
    tick();
    tick();
    chk("rst_irq", irq_o, 0);
    chk("rst_chan", chan_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_completion", completion_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst_ni = 1'b1;
    tick();

    // Round-robin from pointer 0
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    ring(4'b1111);
    repeat (4) serve("rr");
    exp_q.push_back(0); exp_q.push_back(3);
    ring(4'b1001);
    serve("rr2");
    exp_q.push_back(0);
    ring(4'b0001);
    serve("rr2");
    serve("rr2");
    tick();
    tick();

    // Single doorbell with exact latencies
    exp_q.push_back(2);
    doorbell_i = 4'b0100;
    tick();
    doorbell_i = '0;
    chk("single_c1_irq", irq_o, 0);
    tick();
    chk("single_c2_irq", irq_o, 1);
    e = pop_exp();
    chk("single_c2_chan", chan_id_o, e);
    tick();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk("single_c5_busy", busy_o, 1);
    chk("single_c5_irq", irq_o, 0);
    tick();
    complete_i = 1'b1;
    tick();
    complete_i = 1'b0;
    chk("single_c8_completion", completion_o, 4'b0100);
    tick();
    chk("single_c9_completion", completion_o, 0);
    chk("single_c9_busy", busy_o, 0);

    // Wrap-around from pointer 3
    exp_q.push_back(0); exp_q.push_back(1);
    ring(4'b0011);
    serve("wrap");
    serve("wrap");
    tick();
    tick();

    // Overrun and set-wins on claim
    exp_q.push_back(1);
    ring(4'b0010);
    ring(4'b0010);
    chk("ovr_set", overrun_o, 4'b0010);
    wait_irq("ovr");
    e = pop_exp();
    chk("ovr_chan", chan_id_o, e);
    claim_i = 1'b1;
    doorbell_i = 4'b0010;
    exp_q.push_back(1);
    tick();
    claim_i = 1'b0;
    doorbell_i = '0;
    chk("ovr_busy", busy_o, 1);
    complete_i = 1'b1;
    tick();
    complete_i = 1'b0;
    chk("ovr_completion", completion_o, 4'b0010);
    serve("reraise");
    overrun_clr_i = 4'b0010;
    tick();
    overrun_clr_i = '0;
    chk("ovr_clear", overrun_o, 0);

    // Watchdog: channel 3 never completes, channel 0 is served afterwards
    exp_q.push_back(3); exp_q.push_back(0);
    ring(4'b1001);
    wait_irq("wd");
    e = pop_exp();
    chk("wd_chan", chan_id_o, e);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk("wd_busy", busy_o, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        chk($sformatf("wd_quiet_%0d", k), timeout_o, 0);
        chk($sformatf("wd_busy_%0d", k), busy_o, 1);
      end else begin
        chk("wd_fire", timeout_o, 1);
        chk("wd_no_completion", completion_o, 0);
        chk("wd_idle", busy_o, 0);
      end
    end
    tick();
    chk("wd_pulse_end", timeout_o, 0);
    serve("wd_next");
    tick();

    // Reset mid-SERVICE
    exp_q.push_back(1);
    ring(4'b0110);
    wait_irq("mrst");
    e = pop_exp();
    chk("mrst_chan", chan_id_o, e);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    chk("mrst_busy", busy_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mrst_irq", irq_o, 0);
    chk("mrst_busy0", busy_o, 0);
    chk("mrst_chan0", chan_id_o, 0);
    chk("mrst_completion", completion_o, 0);
    tick();
    rst_ni = 1'b1;
    complete_i = 1'b1;
    tick();
    complete_i = 1'b0;
    chk("mrst_ignored_complete", completion_o, 0);
    repeat (3) tick();
    chk("mrst_pending_lost", irq_o, 0);
    chk("mrst_busy_after", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
